// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the D/E forwarding scoreboard: widths, stage indices,
// forwarding-mux select codes and the "operand not read" Tuse value.
package hazard_scoreboard_pkg;

    localparam int DEF_REG_AW = 5;
    localparam int DEF_TW     = 2;

    // Stage-entry layout: one A3/Tnew entry per stage, newest (E) at index 0
    localparam int NUM_STAGES = 3;
    localparam int STG_E      = 0;
    localparam int STG_M      = 1;
    localparam int STG_W      = 2;

    localparam int NUM_OPS    = 2;
    localparam int OP_RS      = 0;
    localparam int OP_RT      = 1;

    typedef enum logic [2:0] {
        ODATA  = 3'b000,
        EDATA  = 3'b001,
        MDATA  = 3'b010,
        WDATA  = 3'b011,
        WWDATA = 3'b100
    } fwd_sel_e;

    // All-ones Tuse marks an operand the D instruction never reads
    function automatic int tuse_none(input int tw);
        return (1 << tw) - 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the pipeline and the hazard scoreboard: D-stage
// operand/destination info in, stall and forwarding selects out.
interface hazard_scoreboard_if #(
    parameter int REG_AW = hazard_scoreboard_pkg::DEF_REG_AW,
    parameter int TW     = hazard_scoreboard_pkg::DEF_TW
);
    import hazard_scoreboard_pkg::*;

    logic [REG_AW-1:0] D_rs;
    logic [REG_AW-1:0] D_rt;
    logic [TW-1:0]     D_Tuse_rs;
    logic [TW-1:0]     D_Tuse_rt;
    logic [REG_AW-1:0] D_A3;
    logic [TW-1:0]     D_Tnew;
    logic              flush_E;

    logic              stall;
    logic [2:0]        s_D_rs_data;
    logic [2:0]        s_D_rt_data;
    logic [2:0]        s_E_rs_data;
    logic [2:0]        s_E_rt_data;

    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_A3, D_Tnew, flush_E,
        input  stall, s_D_rs_data, s_D_rt_data, s_E_rs_data, s_E_rt_data
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_A3, D_Tnew, flush_E,
        output stall, s_D_rs_data, s_D_rt_data, s_E_rs_data, s_E_rt_data
    );

endinterface

// File: rtl/hazard_stage_entry.sv
// One pipeline stage's destination-register / Tnew entry. The E entry loads
// from D (or a bubble), M decrements with saturation, W is always ready.
module hazard_stage_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW = DEF_REG_AW,
    parameter int TW = DEF_TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_bubble,
    input  logic          i_decrement,
    input  logic          i_force_ready,
    input  logic [AW-1:0] i_a3,
    input  logic [TW-1:0] i_tnew,
    output logic [AW-1:0] o_a3,
    output logic [TW-1:0] o_tnew
);

    logic [AW-1:0] r_a3;
    logic [TW-1:0] r_tnew;
    logic [TW-1:0] w_tnew_next;

    always_comb begin
        w_tnew_next = i_tnew;
        if (i_force_ready) begin
            w_tnew_next = '0;
        end else if (i_decrement) begin
            w_tnew_next = (i_tnew == '0) ? '0 : i_tnew - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_bubble) begin
            r_a3   <= '0;
            r_tnew <= '0;
        end else begin
            r_a3   <= i_a3;
            r_tnew <= w_tnew_next;
        end
    end

    assign o_a3   = r_a3;
    assign o_tnew = r_tnew;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the D/E forwarding path: tracks E/M/W producers and
// drives the stall plus the D- and E-stage forwarding mux selects.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW,
    parameter int TW     = DEF_TW
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave bus
);

    localparam logic [TW-1:0] TUSE_NONE = TW'(tuse_none(TW));

    logic [REG_AW-1:0] w_a3   [NUM_STAGES];
    logic [TW-1:0]     w_tnew [NUM_STAGES];
    logic [REG_AW-1:0] w_dsrc [NUM_OPS];
    logic [TW-1:0]     w_dtuse[NUM_OPS];
    logic              w_stall;
    logic              w_bubble;

    function automatic logic f_match(input logic [REG_AW-1:0] a3,
                                     input logic [REG_AW-1:0] r);
        return (a3 == r) && (r != '0);
    endfunction

    assign w_dsrc[OP_RS]  = bus.D_rs;
    assign w_dsrc[OP_RT]  = bus.D_rt;
    assign w_dtuse[OP_RS] = bus.D_Tuse_rs;
    assign w_dtuse[OP_RT] = bus.D_Tuse_rt;

    // A stalled D instruction and an external flush both collapse to one bubble
    assign w_bubble = w_stall | bus.flush_E;

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        logic [REG_AW-1:0] w_in_a3;
        logic [TW-1:0]     w_in_tnew;

        if (gi == STG_E) begin : g_from_d
            assign w_in_a3   = bus.D_A3;
            assign w_in_tnew = bus.D_Tnew;
        end else begin : g_from_prev
            assign w_in_a3   = w_a3[gi-1];
            assign w_in_tnew = w_tnew[gi-1];
        end

        hazard_stage_entry #(
            .AW (REG_AW),
            .TW (TW)
        ) u_entry (
            .clk           (clk),
            .reset         (reset),
            .i_bubble      ((gi == STG_E) ? w_bubble : 1'b0),
            .i_decrement   (gi == STG_M),
            .i_force_ready (gi == STG_W),
            .i_a3          (w_in_a3),
            .i_tnew        (w_in_tnew),
            .o_a3          (w_a3[gi]),
            .o_tnew        (w_tnew[gi])
        );
    end

    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
        logic [REG_AW-1:0] r_e_src;
        logic              w_op_stall;
        fwd_sel_e          w_d_sel;
        fwd_sel_e          w_e_sel;

        always_ff @(posedge clk) begin
            if (reset || w_bubble) begin
                r_e_src <= '0;
            end else begin
                r_e_src <= w_dsrc[gi];
            end
        end

        // Stall when any in-flight producer of this operand is later than its use
        always_comb begin
            w_op_stall = 1'b0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (f_match(w_a3[s], w_dsrc[gi]) && (w_tnew[s] > w_dtuse[gi])) begin
                    w_op_stall = 1'b1;
                end
            end
            if (w_dtuse[gi] == TUSE_NONE) begin
                w_op_stall = 1'b0;
            end
        end

        // Newest matching producer owns the operand, even when not yet ready
        always_comb begin
            w_d_sel = ODATA;
            if (f_match(w_a3[STG_E], w_dsrc[gi])) begin
                if (w_tnew[STG_E] == '0) begin
                    w_d_sel = EDATA;
                end
            end else if (f_match(w_a3[STG_M], w_dsrc[gi])) begin
                if (w_tnew[STG_M] == '0) begin
                    w_d_sel = MDATA;
                end
            end else if (f_match(w_a3[STG_W], w_dsrc[gi])) begin
                w_d_sel = WWDATA;
            end
        end

        always_comb begin
            w_e_sel = ODATA;
            if (f_match(w_a3[STG_M], r_e_src) && (w_tnew[STG_M] == '0)) begin
                w_e_sel = MDATA;
            end else if (f_match(w_a3[STG_W], r_e_src)) begin
                w_e_sel = WDATA;
            end
        end
    end

    assign w_stall         = g_op[OP_RS].w_op_stall | g_op[OP_RT].w_op_stall;
    assign bus.stall       = w_stall;
    assign bus.s_D_rs_data = g_op[OP_RS].w_d_sel;
    assign bus.s_D_rt_data = g_op[OP_RT].w_d_sel;
    assign bus.s_E_rs_data = g_op[OP_RS].w_e_sel;
    assign bus.s_E_rt_data = g_op[OP_RT].w_e_sel;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed pipeline scenarios plus
// random traffic, checked against a stage-list model of the forwarding rules.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int AW = 5;
    localparam int TW = 2;
    localparam int NOUSE = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(AW), .TW(TW)) bus ();

    hazard_scoreboard #(.REG_AW(AW), .TW(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         id;
        logic       stall;
        logic [2:0] drs;
        logic [2:0] drt;
        logic [2:0] ers;
        logic [2:0] ert;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   txn   = 0;

    // Model: in-flight instructions by stage (0=E, 1=M, 2=W), each with its
    // destination and the Tnew it carried into E.
    int m_a3[3];
    int m_tnew_e[3];
    int m_ers, m_ert;
    int cur_rs, cur_rt, cur_urs, cur_urt, cur_a3, cur_tnew;
    bit cur_flush;
    bit cur_reset = 1'b1;
    bit exp_stall_now;

    function automatic int remaining(input int s);
        if (s >= 2) return 0;
        return (m_tnew_e[s] > s) ? m_tnew_e[s] - s : 0;
    endfunction

    function automatic bit hit(input int s, input int r);
        return (r != 0) && (m_a3[s] == r);
    endfunction

    function automatic bit op_stall(input int r, input int tuse);
        if (tuse == NOUSE) return 1'b0;
        for (int s = 0; s < 3; s++)
            if (hit(s, r) && remaining(s) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int d_sel(input int r);
        for (int s = 0; s < 3; s++) begin
            if (hit(s, r)) begin
                if (s == 2) return 4;
                return (remaining(s) == 0) ? s + 1 : 0;
            end
        end
        return 0;
    endfunction

    function automatic int e_sel(input int r);
        if (hit(1, r) && remaining(1) == 0) return 2;
        if (hit(2, r)) return 3;
        return 0;
    endfunction

    function automatic void advance();
        if (cur_reset) begin
            for (int s = 0; s < 3; s++) begin
                m_a3[s] = 0;
                m_tnew_e[s] = 0;
            end
            m_ers = 0;
            m_ert = 0;
        end else begin
            for (int s = 2; s > 0; s--) begin
                m_a3[s] = m_a3[s-1];
                m_tnew_e[s] = m_tnew_e[s-1];
            end
            if (exp_stall_now || cur_flush) begin
                m_a3[0] = 0; m_tnew_e[0] = 0; m_ers = 0; m_ert = 0;
            end else begin
                m_a3[0] = cur_a3; m_tnew_e[0] = cur_tnew; m_ers = cur_rs; m_ert = cur_rt;
            end
        end
    endfunction

    task automatic check_int(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One clock: let the model take the edge, then drive the next D inputs
    // and queue the expected combinational response.
    task automatic step(input bit rst, input int rs, input int rt, input int urs,
                        input int urt, input int a3, input int tnew, input bit fl);
        exp_t e;
        @(posedge clk);
        advance();
        #1;
        reset = rst;
        bus.D_rs = AW'(rs);       bus.D_rt = AW'(rt);
        bus.D_Tuse_rs = TW'(urs); bus.D_Tuse_rt = TW'(urt);
        bus.D_A3 = AW'(a3);       bus.D_Tnew = TW'(tnew);
        bus.flush_E = fl;
        cur_reset = rst; cur_rs = rs; cur_rt = rt; cur_urs = urs; cur_urt = urt;
        cur_a3 = a3; cur_tnew = tnew; cur_flush = fl;
        exp_stall_now = op_stall(rs, urs) | op_stall(rt, urt);
        e.id = txn; e.stall = exp_stall_now;
        e.drs = 3'(d_sel(rs)); e.drt = 3'(d_sel(rt));
        e.ers = 3'(e_sel(m_ers)); e.ert = 3'(e_sel(m_ert));
        exp_q.push_back(e);
        txn++;
    endtask

    // Present an instruction in D and hold it while the DUT stalls; returns
    // the number of stall cycles observed, ending 2 time units after an edge.
    task automatic issue(input int rs, input int rt, input int urs, input int urt,
                         input int a3, input int tnew, output int stalls);
        stalls = 0;
        step(1'b0, rs, rt, urs, urt, a3, tnew, 1'b0);
        #1;
        for (int k = 0; k < 6 && bus.stall === 1'b1; k++) begin
            stalls++;
            step(1'b0, rs, rt, urs, urt, a3, tnew, 1'b0);
            #1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("[TB] txn %0d stall=%0b sD=%0d/%0d sE=%0d/%0d (exp %0b %0d/%0d %0d/%0d)",
                         e.id, bus.stall, bus.s_D_rs_data, bus.s_D_rt_data,
                         bus.s_E_rs_data, bus.s_E_rt_data,
                         e.stall, e.drs, e.drt, e.ers, e.ert);
                check_int("stall", int'(bus.stall), int'(e.stall));
                check_int("s_D_rs_data", int'(bus.s_D_rs_data), int'(e.drs));
                check_int("s_D_rt_data", int'(bus.s_D_rt_data), int'(e.drt));
                check_int("s_E_rs_data", int'(bus.s_E_rs_data), int'(e.ers));
                check_int("s_E_rt_data", int'(bus.s_E_rt_data), int'(e.ert));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        reset = 1'b1;
        bus.D_rs = '0; bus.D_rt = '0; bus.D_Tuse_rs = '1; bus.D_Tuse_rt = '1;
        bus.D_A3 = AW'(5); bus.D_Tnew = TW'(1); bus.flush_E = 1'b0;

        // Reset held two cycles with a live destination in D, then released
        step(1'b1, 0, 0, NOUSE, NOUSE, 5, 1, 1'b0);
        step(1'b1, 0, 0, NOUSE, NOUSE, 5, 1, 1'b0);
        #1;
        check_int("reset_stall", int'(bus.stall), 0);
        check_int("reset_sel", int'(bus.s_D_rs_data), 0);
        step(1'b0, 0, 0, NOUSE, NOUSE, 5, 1, 1'b0);
        step(1'b0, 0, 0, NOUSE, NOUSE, 0, 0, 1'b0);

        // ALU result consumed by a branch compare in D
        issue(1, 2, 1, 1, 3, 1, n);
        issue(3, 0, 0, 0, 0, 0, n);
        check_int("alu_br_stalls", n, 1);
        check_int("alu_br_sel", int'(bus.s_D_rs_data), 2);

        // Load then dependent ALU op
        issue(1, 0, 1, NOUSE, 4, 2, n);
        issue(4, 5, 1, 1, 6, 1, n);
        check_int("load_use_stalls", n, 1);
        step(1'b0, 0, 0, NOUSE, NOUSE, 0, 0, 1'b0);
        #1;
        check_int("load_use_esel", int'(bus.s_E_rs_data), 3);

        // Load then dependent branch
        issue(1, 0, 1, NOUSE, 4, 2, n);
        issue(4, 0, 0, 0, 0, 0, n);
        check_int("load_br_stalls", n, 2);
        check_int("load_br_sel", int'(bus.s_D_rs_data), 4);

        // jal then jr
        issue(0, 0, NOUSE, NOUSE, 31, 0, n);
        issue(31, 0, 0, NOUSE, 0, 0, n);
        check_int("jal_jr_stalls", n, 0);
        check_int("jal_jr_sel", int'(bus.s_D_rs_data), 1);

        // Register 0 never causes a stall
        issue(0, 0, NOUSE, NOUSE, 0, 2, n);
        issue(0, 0, 0, 0, 0, 0, n);
        check_int("zero_stalls", n, 0);
        check_int("zero_sel", int'(bus.s_D_rs_data), 0);

        // Same register in E and M: the E copy wins
        issue(0, 0, NOUSE, NOUSE, 7, 1, n);
        issue(0, 0, NOUSE, NOUSE, 7, 0, n);
        issue(7, 0, 0, NOUSE, 0, 0, n);
        check_int("prio_sel", int'(bus.s_D_rs_data), 1);

        // Flush coinciding with a stall, then reset while stalled
        issue(1, 0, 1, NOUSE, 4, 2, n);
        step(1'b0, 4, 0, 0, NOUSE, 0, 0, 1'b1);
        step(1'b1, 4, 0, 0, NOUSE, 0, 0, 1'b0);
        step(1'b0, 4, 0, 0, NOUSE, 0, 0, 1'b0);
        #1;
        check_int("rst_mid_stall", int'(bus.stall), 0);

        // Random traffic; D is usually held while stalled, as the real pipeline does
        for (int i = 0; i < 600; i++) begin
            bit rst;
            rst = ($urandom_range(0, 39) == 0);
            if (exp_stall_now && $urandom_range(0, 3) != 0 && !rst) begin
                step(1'b0, cur_rs, cur_rt, cur_urs, cur_urt, cur_a3, cur_tnew,
                     ($urandom_range(0, 7) == 0));
            end else begin
                step(rst, $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 7), $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0));
            end
        end

        step(1'b0, 0, 0, NOUSE, NOUSE, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check_int("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
